// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_BURST_LEN = 4;
  localparam int unsigned STAT_W        = 16;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set request bit at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  int unsigned j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-producer accepted-word counters when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr_e,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]   stat_count
`endif
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  arb_state_e        state_q;
  logic [ID_W-1:0]   owner_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_idx;
  logic [CNT_W-1:0]  count_inc;
  logic              last_beat;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + ID_W'(1);
  endfunction

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Same-cycle grant decision; reset low or a full FIFO blocks every grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = owner_q;
    if (reset && !fifo_full) begin
      case (state_q)
        IDLE: begin
          gnt_vld = pick_found;
          gnt_idx = pick_idx;
        end
        BURST: begin
          gnt_vld = req_valid[owner_q];
          gnt_idx = owner_q;
        end
        default: gnt_vld = 1'b0;
      endcase
    end
  end

  always_comb begin
    req_ready    = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    fifo_wr_e    = gnt_vld;
    fifo_data_in = gnt_vld ? req_data[32'(gnt_idx)*DATA_W +: DATA_W] : '0;
    count_inc    = count_q + CNT_W'(1);
    last_beat    = (count_inc == CNT_W'(BURST_LEN));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            grant_id <= gnt_idx;
            owner_q  <= gnt_idx;
            if (BURST_LEN > 1) begin
              state_q <= BURST;
              busy    <= 1'b1;
              count_q <= CNT_W'(1);
            end else begin
              rr_ptr_q <= wrap_inc(gnt_idx);
            end
          end
        end
        BURST: begin
          // A full FIFO stalls the burst without giving up ownership.
          if (!fifo_full) begin
            if (gnt_vld) begin
              grant_id <= owner_q;
              count_q  <= count_inc;
              if (last_beat) begin
                state_q  <= IDLE;
                busy     <= 1'b0;
                count_q  <= '0;
                rr_ptr_q <= wrap_inc(owner_q);
              end
            end else begin
              state_q  <= IDLE;
              busy     <= 1'b0;
              count_q  <= '0;
              rr_ptr_q <= wrap_inc(owner_q);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  // Saturating count of accepted words per producer.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else if (req_ready[i] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + STAT_W'(1);
      end
    end
    assign stat_count[i*STAT_W +: STAT_W] = cnt_q;
  end
`endif

endmodule
